exc_ctrl: RTL and testbench

Parametrised exception/interrupt controller for the single-cycle LEGv8 core. It works beside the main decoder and handles N external interrupt lines plus the decoder's invalid-opcode trap. It arbitrates by fixed priority, captures the return PC and status, tracks handler mode until ERET, and halts on a double fault. It owns the exception state that the datapath reads through MRS and uses for the vector redirect.

---
 rtl/exc_ctrl_if.sv | 30 +++
 rtl/exc_ctrl.sv | 155 +++++++++++++++
 tb/tb_exc_ctrl.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/exc_ctrl_if.sv
// rtl/exc_ctrl_if.sv - core-side request/response bundle for the exception controller
interface exc_ctrl_if #(
    parameter int N_IRQ = 4,
    parameter int PC_W  = 64,
    parameter int ID_W  = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
);
    logic [N_IRQ-1:0] ExtIRQ;
    logic [N_IRQ-1:0] IRQMask;
    logic             BadOpcode;
    logic             ERet;
    logic [PC_W-1:0]  PC_in;

    logic             ExcTaken;
    logic [N_IRQ-1:0] IRQAck;
    logic [ID_W-1:0]  IRQId;
    logic [PC_W-1:0]  ELR;
    logic [3:0]       EStatus;
    logic             InExc;
    logic             Halt;

    modport master (
        output ExtIRQ, IRQMask, BadOpcode, ERet, PC_in,
        input  ExcTaken, IRQAck, IRQId, ELR, EStatus, InExc, Halt
    );

    modport slave (
        input  ExtIRQ, IRQMask, BadOpcode, ERet, PC_in,
        output ExcTaken, IRQAck, IRQId, ELR, EStatus, InExc, Halt
    );
endinterface

// File: rtl/exc_ctrl.sv
// rtl/exc_ctrl.sv - fixed-priority exception/interrupt controller with double-fault halt
module exc_ctrl #(
    parameter int N_IRQ = 4,
    parameter int PC_W  = 64
) (
    input  logic        clk,
    input  logic        reset,
    exc_ctrl_if.slave   bus
);
    localparam int ID_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

    localparam logic [3:0] ST_NONE   = 4'b0000;
    localparam logic [3:0] ST_IRQ    = 4'b0001;
    localparam logic [3:0] ST_BADOP  = 4'b0010;
    localparam logic [3:0] ST_DFAULT = 4'b1111;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        ENTER   = 2'd1,
        HANDLER = 2'd2,
        HALT    = 2'd3
    } state_t;

    state_t           state, state_n;
    logic [N_IRQ-1:0] prev;
    logic [N_IRQ-1:0] pending, pending_n;
    logic             armed;
    logic [PC_W-1:0]  elr, elr_n;
    logic [3:0]       estatus, estatus_n;
    logic [ID_W-1:0]  irq_id, irq_id_n;
    logic             entry_irq, entry_irq_n;

    logic [N_IRQ-1:0] rise;
    logic [N_IRQ-1:0] eligible;
    logic             any_eligible;
    logic [ID_W-1:0]  winner;
    logic             take_irq;
    logic [N_IRQ-1:0] clr;
    logic [N_IRQ-1:0] ack;

    // prev only becomes meaningful after one edge out of reset; until then a
    // line that was already high must not look like a fresh event.
    assign rise     = armed ? (bus.ExtIRQ & ~prev) : '0;
    assign eligible = pending & ~bus.IRQMask;

    always_comb begin
        any_eligible = |eligible;
        winner       = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                winner = ID_W'(i);
            end
        end
    end

    always_comb begin
        state_n     = state;
        elr_n       = elr;
        estatus_n   = estatus;
        irq_id_n    = irq_id;
        entry_irq_n = entry_irq;
        take_irq    = 1'b0;
        case (state)
            RUN: begin
                if (bus.BadOpcode) begin
                    state_n     = ENTER;
                    elr_n       = bus.PC_in;
                    estatus_n   = ST_BADOP;
                    entry_irq_n = 1'b0;
                end else if (any_eligible) begin
                    state_n     = ENTER;
                    elr_n       = bus.PC_in;
                    estatus_n   = ST_IRQ;
                    irq_id_n    = winner;
                    entry_irq_n = 1'b1;
                    take_irq    = 1'b1;
                end
            end
            ENTER: begin
                if (bus.BadOpcode) begin
                    state_n   = HALT;
                    estatus_n = ST_DFAULT;
                end else begin
                    state_n = HANDLER;
                end
            end
            HANDLER: begin
                // A fault inside the handler outranks the return.
                if (bus.BadOpcode) begin
                    state_n   = HALT;
                    estatus_n = ST_DFAULT;
                end else if (bus.ERet) begin
                    state_n   = RUN;
                    estatus_n = ST_NONE;
                end
            end
            HALT: begin
                state_n = HALT;
            end
            default: begin
                state_n = RUN;
            end
        endcase
    end

    always_comb begin
        clr = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            if (take_irq && (winner == ID_W'(i))) begin
                clr[i] = 1'b1;
            end
        end
        // A new rising edge on the channel being taken keeps it pending.
        pending_n = (pending & ~clr) | rise;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= RUN;
            prev      <= '0;
            pending   <= '0;
            armed     <= 1'b0;
            elr       <= '0;
            estatus   <= ST_NONE;
            irq_id    <= '0;
            entry_irq <= 1'b0;
        end else begin
            state     <= state_n;
            prev      <= bus.ExtIRQ;
            pending   <= pending_n;
            armed     <= 1'b1;
            elr       <= elr_n;
            estatus   <= estatus_n;
            irq_id    <= irq_id_n;
            entry_irq <= entry_irq_n;
        end
    end

    always_comb begin
        ack = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            if ((state == ENTER) && entry_irq && (irq_id == ID_W'(i))) begin
                ack[i] = 1'b1;
            end
        end
    end

    assign bus.ExcTaken = (state == ENTER);
    assign bus.IRQAck   = ack;
    assign bus.IRQId    = irq_id;
    assign bus.ELR      = elr;
    assign bus.EStatus  = estatus;
    assign bus.InExc    = (state == ENTER) || (state == HANDLER);
    assign bus.Halt     = (state == HALT);
endmodule

// File: tb/tb_exc_ctrl.sv
// tb/tb_exc_ctrl.sv - scoreboard bench for exc_ctrl: entries queued, monitor compares
module tb_exc_ctrl;
    localparam int N_IRQ = 4;
    localparam int PC_W  = 64;

    typedef struct packed {
        logic [3:0]  ack;
        logic [3:0]  st;
        logic [1:0]  id;
        logic [63:0] elr;
    } exp_t;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;
    exp_t exp_q[$];

    exc_ctrl_if #(.N_IRQ(N_IRQ), .PC_W(PC_W)) bus ();

    exc_ctrl #(.N_IRQ(N_IRQ), .PC_W(PC_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_entry(input logic [3:0] ack, input logic [3:0] st,
                                input logic [1:0] id, input logic [63:0] elr);
        exp_t e;
        e.ack = ack;
        e.st  = st;
        e.id  = id;
        e.elr = elr;
        exp_q.push_back(e);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_exctaken"}, 64'(bus.ExcTaken), 64'd0);
        check({tag, "_irqack"},   64'(bus.IRQAck),   64'd0);
        check({tag, "_irqid"},    64'(bus.IRQId),    64'd0);
        check({tag, "_elr"},      bus.ELR,           64'd0);
        check({tag, "_estatus"},  64'(bus.EStatus),  64'd0);
        check({tag, "_inexc"},    64'(bus.InExc),    64'd0);
        check({tag, "_halt"},     64'(bus.Halt),     64'd0);
    endtask

    // Monitor: every entry pulse must match the head of the expectation queue.
    always @(negedge clk) begin
        if (reset && bus.ExcTaken) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_entry: ExcTaken=1 with no entry expected at %0t", $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("mon_irqack",  64'(bus.IRQAck),  64'(e.ack));
                check("mon_estatus", 64'(bus.EStatus), 64'(e.st));
                check("mon_irqid",   64'(bus.IRQId),   64'(e.id));
                check("mon_elr",     bus.ELR,          e.elr);
                check("mon_inexc",   64'(bus.InExc),   64'd1);
            end
        end else if (reset) begin
            check("mon_ack_idle", 64'(bus.IRQAck), 64'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t expected below 200000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset         = 1'b0;
        bus.ExtIRQ    = '0;
        bus.IRQMask   = '0;
        bus.BadOpcode = 1'b0;
        bus.ERet      = 1'b0;
        bus.PC_in     = '0;
        tick();
        tick();
        check_reset_values("rst");
        reset = 1'b1;
        tick();

        // IRQ entry and return on channel 2
        bus.PC_in  = 64'h40;
        bus.ExtIRQ = 4'b0100;
        expect_entry(4'b0100, 4'b0001, 2'd2, 64'h40);
        tick();
        check("irq_not_yet", 64'(bus.ExcTaken), 64'd0);
        tick();
        check("irq_enter_taken", 64'(bus.ExcTaken), 64'd1);
        tick();
        check("irq_handler_pulse", 64'(bus.ExcTaken), 64'd0);
        check("irq_handler_inexc", 64'(bus.InExc), 64'd1);
        bus.ERet = 1'b1;
        tick();
        bus.ERet = 1'b0;
        check("ret_estatus", 64'(bus.EStatus), 64'd0);
        check("ret_inexc",   64'(bus.InExc),   64'd0);
        check("ret_elr",     bus.ELR,          64'h40);
        check("ret_irqid",   64'(bus.IRQId),   64'd2);
        bus.ExtIRQ = '0;
        tick();

        // Priority with masking, no nesting
        bus.PC_in   = 64'h80;
        bus.IRQMask = 4'b0010;
        bus.ExtIRQ  = 4'b1010;
        expect_entry(4'b1000, 4'b0001, 2'd3, 64'h80);
        tick();
        tick();
        tick();
        bus.IRQMask = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("nonest_inexc", 64'(bus.InExc), 64'd1);
        end
        bus.PC_in = 64'h84;
        expect_entry(4'b0010, 4'b0001, 2'd1, 64'h84);
        bus.ERet = 1'b1;
        tick();
        bus.ERet = 1'b0;
        check("gap_run_inexc", 64'(bus.InExc), 64'd0);
        tick();
        check("ch1_entered", 64'(bus.ExcTaken), 64'd1);
        tick();
        bus.ERet = 1'b1;
        tick();
        bus.ERet   = 1'b0;
        bus.ExtIRQ = '0;
        tick();

        // Trap beats a pending eligible IRQ
        bus.ExtIRQ = 4'b0001;
        tick();
        bus.BadOpcode = 1'b1;
        bus.PC_in     = 64'h100;
        expect_entry(4'b0000, 4'b0010, 2'd1, 64'h100);
        tick();
        bus.BadOpcode = 1'b0;
        tick();
        bus.PC_in = 64'h104;
        expect_entry(4'b0001, 4'b0001, 2'd0, 64'h104);
        bus.ERet = 1'b1;
        tick();
        bus.ERet = 1'b0;
        tick();
        tick();

        // Set beats clear: second edge of channel 0 lands on its take edge
        bus.ExtIRQ = 4'b0000;
        tick();
        bus.ExtIRQ = 4'b0001;
        tick();
        bus.ExtIRQ = 4'b0000;
        tick();
        bus.ERet = 1'b1;
        tick();
        bus.ERet   = 1'b0;
        bus.ExtIRQ = 4'b0001;
        bus.PC_in  = 64'h180;
        expect_entry(4'b0001, 4'b0001, 2'd0, 64'h180);
        tick();
        tick();
        bus.PC_in = 64'h1C0;
        expect_entry(4'b0001, 4'b0001, 2'd0, 64'h1C0);
        bus.ERet = 1'b1;
        tick();
        bus.ERet = 1'b0;
        tick();
        tick();
        check("second_entry_handler", 64'(bus.InExc), 64'd1);

        // Double fault
        bus.BadOpcode = 1'b1;
        bus.PC_in     = 64'h200;
        tick();
        bus.BadOpcode = 1'b0;
        check("df_estatus", 64'(bus.EStatus), 64'hF);
        check("df_halt",    64'(bus.Halt),    64'd1);
        check("df_inexc",   64'(bus.InExc),   64'd0);
        check("df_elr",     bus.ELR,          64'h1C0);
        bus.ERet = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.ExtIRQ = 4'(i[0] ? 4'b1111 : 4'b0000);
            tick();
        end
        bus.ERet = 1'b0;
        check("halt_sticky",   64'(bus.Halt),    64'd1);
        check("halt_estatus",  64'(bus.EStatus), 64'hF);
        check("halt_elr",      bus.ELR,          64'h1C0);

        // Asynchronous reset out of HALT
        reset = 1'b0;
        #1;
        check_reset_values("rst_halt");
        bus.ExtIRQ = '0;
        tick();
        reset = 1'b1;
        tick();

        // Enter a handler, then reset mid-handler with no clock edge
        bus.BadOpcode = 1'b1;
        bus.PC_in     = 64'h300;
        expect_entry(4'b0000, 4'b0010, 2'd0, 64'h300);
        tick();
        bus.BadOpcode = 1'b0;
        tick();
        check("pre_rst_inexc", 64'(bus.InExc), 64'd1);
        bus.ExtIRQ = 4'b0001;
        tick();
        reset = 1'b0;
        #1;
        check_reset_values("rst_mid");

        // Line held high through reset release must not be taken
        tick();
        tick();
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("held_high_no_entry", 64'(bus.InExc), 64'd0);
        end
        check("held_high_estatus", 64'(bus.EStatus), 64'd0);

        tick();
        check("all_entries_seen", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
